inst_fetch_unit: RTL

- Initiator side of the instruction-memory interface: owns the program counter, drives PC to INST_MEM and captures the returned INST_CODE.
- Presents each fetched instruction and its address to decode with a valid/ready handshake.
- Handles stall (backpressure), halt (FETCH_EN low) and redirect (branch/jump/trap target) with flush.
- Sits between the PC logic and decode in the single-cycle core, replacing the free-running PC increment.

---
 rtl/riscv_fetch_pkg.sv | 15 +
 rtl/fetch_pc_gen.sv | 26 ++
 rtl/inst_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INST             = 32'h00000013;
    localparam int unsigned INST_STRIDE          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h00000000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC select: hold, sequential advance, or word-aligned redirect target.
module fetch_pc_gen
    import riscv_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                advance_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] STRIDE     = PC_WIDTH'(INST_STRIDE);

    always_comb begin
        pc_next_o = pc_i;
        unique case (1'b1)
            redirect_i: pc_next_o = redirect_pc_i & ALIGN_MASK;
            advance_i:  pc_next_o = pc_i + STRIDE;
            default:    pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit with valid/ready output, stall, halt and redirect.
// Define FETCH_STATS_EN to add FETCH_COUNT / REDIRECT_COUNT outputs.
module inst_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int                PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic [PC_WIDTH-1:0] PC,
    input  logic [31:0]         INST_CODE,
    input  logic                FETCH_EN,
    input  logic                REDIRECT_VALID,
    input  logic [PC_WIDTH-1:0] REDIRECT_PC,
    output logic                INST_VALID,
    input  logic                INST_READY,
    output logic [31:0]         INST_OUT,
    output logic [PC_WIDTH-1:0] INST_PC
`ifdef FETCH_STATS_EN
   ,output logic [31:0]         FETCH_COUNT,
    output logic [15:0]         REDIRECT_COUNT
`endif
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q, valid_d;
    logic [31:0]         inst_q, inst_d;
    logic [PC_WIDTH-1:0] ipc_q, ipc_d;
    logic                capture;

    // Redirect wins over capture; BOOT never captures.
    assign capture = !REDIRECT_VALID && (state_q != BOOT) && FETCH_EN &&
                     (!valid_q || INST_READY);

    fetch_pc_gen #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc_gen (
        .pc_i          (pc_q),
        .advance_i     (capture),
        .redirect_i    (REDIRECT_VALID),
        .redirect_pc_i (REDIRECT_PC),
        .pc_next_o     (pc_d)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        if (REDIRECT_VALID) begin
            valid_d = 1'b0;
            case (state_q)
                BOOT:    state_d = FETCH_EN ? RUN : HALT;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end else if (state_q == BOOT) begin
            state_d = FETCH_EN ? RUN : HALT;
        end else if (capture) begin
            valid_d = 1'b1;
            inst_d  = INST_CODE;
            ipc_d   = pc_q;
            state_d = RUN;
        end else if (valid_q && !INST_READY) begin
            state_d = STALL;
        end else begin
            // Fetch disabled and nothing left to hold: drain into HALT.
            valid_d = 1'b0;
            state_d = HALT;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            ipc_q   <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end

    assign PC         = pc_q;
    assign INST_VALID = valid_q;
    assign INST_OUT   = inst_q;
    assign INST_PC    = ipc_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fcnt_q;
    logic [15:0] rcnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (capture)
                fcnt_q <= fcnt_q + 32'd1;
            if (REDIRECT_VALID)
                rcnt_q <= rcnt_q + 16'd1;
        end
    end

    assign FETCH_COUNT    = fcnt_q;
    assign REDIRECT_COUNT = rcnt_q;
`endif

endmodule
